// File: rtl/calc_reader.sv
// calc_reader: sequences a 4-lane readout from a match accumulator and keeps
// the lane with the lowest signed score, score = g2sum - 2*fg.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   start                 readout request, honoured only when idle
//   g2sum, gsum, fg, place  values for the lane the accumulator presents
//   finalstart            strobe: accumulator selects lane 0
//   valid                 strobe: accumulator advances to the next lane
//   busy, done            readout in progress / one-cycle completion pulse
//   best_place, best_score, best_valid  result of the last readout
//
// Optional feature: define CALC_READER_ZERO_SKIP_EN to exclude lanes whose
// gsum is zero from best selection. Default build treats every lane as eligible.
module calc_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] g2sum,
  input  logic [10:0] gsum,
  input  logic [13:0] fg,
  input  logic [5:0]  place,
  output logic        finalstart,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic [5:0]  best_place,
  output logic [15:0] best_score,
  output logic        best_valid
);

  typedef enum logic [2:0] {IDLE, STROBE, SETTLE, CAPTURE, FIN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_idx_q, lane_idx_d;
  logic [5:0]  best_place_q, best_place_d;
  logic [15:0] best_score_q, best_score_d;
  logic        best_valid_q, best_valid_d;

  logic [15:0] score;
  logic        eligible;

  // Range is -32766..16383, so 16-bit two's complement never wraps.
  assign score = {2'b00, g2sum} - {1'b0, fg, 1'b0};

`ifdef CALC_READER_ZERO_SKIP_EN
  assign eligible = (gsum != 11'd0);
`else
  logic unused_gsum;
  assign unused_gsum = ^gsum;
  assign eligible    = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    lane_idx_d   = lane_idx_q;
    best_place_d = best_place_q;
    best_score_d = best_score_q;
    best_valid_d = best_valid_q;
    finalstart   = 1'b0;
    valid        = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = STROBE;
          lane_idx_d   = 2'd0;
          best_place_d = 6'd0;
          best_score_d = 16'd0;
          best_valid_d = 1'b0;
        end
      end
      STROBE: begin
        finalstart = (lane_idx_q == 2'd0);
        valid      = (lane_idx_q != 2'd0);
        state_d    = SETTLE;
      end
      SETTLE:  state_d = CAPTURE;
      CAPTURE: begin
        // Strict less-than keeps the earlier lane on a tie.
        if (eligible && (!best_valid_q || ($signed(score) < $signed(best_score_q)))) begin
          best_place_d = place;
          best_score_d = score;
          best_valid_d = 1'b1;
        end
        if (lane_idx_q == 2'd3) begin
          state_d = FIN;
        end else begin
          lane_idx_d = lane_idx_q + 2'd1;
          state_d    = STROBE;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lane_idx_q   <= 2'd0;
      best_place_q <= 6'd0;
      best_score_q <= 16'd0;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_idx_q   <= lane_idx_d;
      best_place_q <= best_place_d;
      best_score_q <= best_score_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign best_place = best_place_q;
  assign best_score = best_score_q;
  assign best_valid = best_valid_q;

endmodule

// File: tb/tb_calc_reader.sv
// Directed bench for calc_reader. A small accumulator model presents lane
// values selected by finalstart/valid; each test records per-cycle strobe
// masks relative to the start-sampling edge and checks results.
`timescale 1ns/1ps
module tb_calc_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] g2sum;
  logic [10:0] gsum;
  logic [13:0] fg;
  logic [5:0]  place;
  logic        finalstart, valid, busy, done, best_valid;
  logic [5:0]  best_place;
  logic [15:0] best_score;

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] g2 [4];
  logic [10:0] gs [4];
  logic [13:0] fv [4];
  logic [5:0]  pl [4];
  logic [1:0]  acc_lane = 2'd0;

  logic [31:0] fs_m, vl_m, dn_m, bz_m;

  calc_reader dut (
    .clk(clk), .rst(rst), .start(start), .g2sum(g2sum), .gsum(gsum), .fg(fg),
    .place(place), .finalstart(finalstart), .valid(valid), .busy(busy),
    .done(done), .best_place(best_place), .best_score(best_score),
    .best_valid(best_valid)
  );

  always #5 clk = ~clk;

  // Accumulator model: finalstart selects lane 0, valid advances.
  always @(posedge clk) begin
    if (finalstart) acc_lane <= 2'd0;
    else if (valid) acc_lane <= acc_lane + 2'd1;
  end
  assign g2sum = g2[acc_lane];
  assign gsum  = gs[acc_lane];
  assign fg    = fv[acc_lane];
  assign place = pl[acc_lane];

  task automatic set_lane(input int i, input int a, input int f, input int p, input int s);
    g2[i] = 14'(a); fv[i] = 14'(f); pl[i] = 6'(p); gs[i] = 11'(s);
  endtask

  // Start is sampled at the posedge that is cycle 0; the k-th following
  // negedge lies in cycle k. start2_k re-pulses start so it is sampled at
  // cycle start2_k; rst_k asserts reset during cycle rst_k for two cycles.
  task automatic run_readout(input int start2_k, input int rst_k);
    fs_m = '0; vl_m = '0; dn_m = '0; bz_m = '0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      fs_m[k] = finalstart; vl_m[k] = valid; dn_m[k] = done; bz_m[k] = busy;
      if (k == start2_k - 1) start = 1'b1;
      if (k == start2_k) start = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 2) rst = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (finalstart !== 1'b0) begin n_bad++; $display("FAIL reset_finalstart got=%b exp=0", finalstart); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (best_place !== 6'd0) begin n_bad++; $display("FAIL reset_best_place got=%0d exp=0", best_place); end
    n_cmp++; if (best_score !== 16'd0) begin n_bad++; $display("FAIL reset_best_score got=%h exp=0000", best_score); end
    n_cmp++; if (best_valid !== 1'b0) begin n_bad++; $display("FAIL reset_best_valid got=%b exp=0", best_valid); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    set_lane(0, 100, 10, 0, 1); set_lane(1, 50, 40, 16, 1);
    set_lane(2, 80, 20, 32, 1); set_lane(3, 90, 60, 48, 1);
    run_readout(0, -10);
    n_cmp++; if (fs_m !== 32'h0000_0002) begin n_bad++; $display("FAIL basic_finalstart_cycles got=%h exp=00000002", fs_m); end
    n_cmp++; if (vl_m !== 32'h0000_0490) begin n_bad++; $display("FAIL basic_valid_cycles got=%h exp=00000490", vl_m); end
    n_cmp++; if (dn_m !== 32'h0000_2000) begin n_bad++; $display("FAIL basic_done_cycles got=%h exp=00002000", dn_m); end
    n_cmp++; if (bz_m !== 32'h0000_3FFE) begin n_bad++; $display("FAIL basic_busy_cycles got=%h exp=00003ffe", bz_m); end
    n_cmp++; if (best_place !== 6'd16) begin n_bad++; $display("FAIL basic_best_place got=%0d exp=16", best_place); end
    n_cmp++; if (best_score !== 16'hFFE2) begin n_bad++; $display("FAIL basic_best_score got=%h exp=ffe2", best_score); end
    n_cmp++; if (best_valid !== 1'b1) begin n_bad++; $display("FAIL basic_best_valid got=%b exp=1", best_valid); end
    // Result must hold while idle.
    repeat (5) @(negedge clk);
    n_cmp++; if (best_place !== 6'd16 || best_score !== 16'hFFE2) begin n_bad++; $display("FAIL basic_hold got=%0d/%h exp=16/ffe2", best_place, best_score); end
  endtask

  task automatic test_restart_ignored;
    run_readout(5, -10);
    n_cmp++; if (dn_m !== 32'h0000_2000) begin n_bad++; $display("FAIL restart_done_cycles got=%h exp=00002000", dn_m); end
    n_cmp++; if (fs_m !== 32'h0000_0002) begin n_bad++; $display("FAIL restart_finalstart_cycles got=%h exp=00000002", fs_m); end
    n_cmp++; if (best_place !== 6'd16) begin n_bad++; $display("FAIL restart_best_place got=%0d exp=16", best_place); end
  endtask

  task automatic test_reset_abort;
    run_readout(0, 8);
    n_cmp++; if (dn_m !== 32'h0) begin n_bad++; $display("FAIL abort_done_cycles got=%h exp=00000000", dn_m); end
    n_cmp++; if (bz_m !== 32'h0000_01FE) begin n_bad++; $display("FAIL abort_busy_cycles got=%h exp=000001fe", bz_m); end
    n_cmp++; if (best_valid !== 1'b0) begin n_bad++; $display("FAIL abort_best_valid got=%b exp=0", best_valid); end
    // scores 180, 100, -10, 100 -> lane 2
    set_lane(0, 200, 10, 1, 1); set_lane(1, 100, 0, 2, 1);
    set_lane(2, 0, 5, 3, 1);    set_lane(3, 300, 100, 4, 1);
    run_readout(0, -10);
    n_cmp++; if (fs_m !== 32'h0000_0002 || dn_m !== 32'h0000_2000) begin n_bad++; $display("FAIL abort_rerun_timing got=%h/%h exp=00000002/00002000", fs_m, dn_m); end
    n_cmp++; if (best_place !== 6'd3) begin n_bad++; $display("FAIL abort_rerun_place got=%0d exp=3", best_place); end
    n_cmp++; if (best_score !== 16'hFFF6) begin n_bad++; $display("FAIL abort_rerun_score got=%h exp=fff6", best_score); end
  endtask

  task automatic test_extreme;
    // scores 100, -32766, 5, 16383
    set_lane(0, 100, 0, 7, 1);   set_lane(1, 0, 16383, 9, 1);
    set_lane(2, 5, 0, 11, 1);    set_lane(3, 16383, 0, 13, 1);
    run_readout(0, -10);
    n_cmp++; if (best_place !== 6'd9) begin n_bad++; $display("FAIL extreme_place got=%0d exp=9", best_place); end
    n_cmp++; if (best_score !== 16'h8002) begin n_bad++; $display("FAIL extreme_score got=%h exp=8002", best_score); end
  endtask

  task automatic test_back_to_back;
    // Equal scores: first lane wins; old best (-32766) must be cleared on start.
    set_lane(0, 10, 0, 5, 1); set_lane(1, 10, 0, 6, 1);
    set_lane(2, 10, 0, 7, 1); set_lane(3, 10, 0, 8, 1);
    run_readout(0, -10);
    n_cmp++; if (best_place !== 6'd5) begin n_bad++; $display("FAIL b2b_tie_place got=%0d exp=5", best_place); end
    n_cmp++; if (best_score !== 16'd10) begin n_bad++; $display("FAIL b2b_score got=%h exp=000a", best_score); end
    n_cmp++; if (best_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_best_valid got=%b exp=1", best_valid); end
  endtask

`ifdef CALC_READER_ZERO_SKIP_EN
  task automatic test_zero_skip;
    set_lane(0, 0, 100, 1, 0); set_lane(1, 0, 200, 2, 0);
    set_lane(2, 0, 300, 3, 0); set_lane(3, 16383, 0, 44, 5);
    run_readout(0, -10);
    n_cmp++; if (best_place !== 6'd44) begin n_bad++; $display("FAIL zskip_place got=%0d exp=44", best_place); end
    n_cmp++; if (best_score !== 16'd16383) begin n_bad++; $display("FAIL zskip_score got=%h exp=3fff", best_score); end
    n_cmp++; if (best_valid !== 1'b1) begin n_bad++; $display("FAIL zskip_valid got=%b exp=1", best_valid); end
    gs[3] = 11'd0;
    run_readout(0, -10);
    n_cmp++; if (dn_m !== 32'h0000_2000) begin n_bad++; $display("FAIL zskip_all_done got=%h exp=00002000", dn_m); end
    n_cmp++; if (best_valid !== 1'b0 || best_place !== 6'd0) begin n_bad++; $display("FAIL zskip_all_result got=%b/%0d exp=0/0", best_valid, best_place); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) set_lane(i, 0, 0, 0, 1);
    test_reset;
    test_basic;
    test_restart_ignored;
    test_reset_abort;
    test_extreme;
    test_back_to_back;
`ifdef CALC_READER_ZERO_SKIP_EN
    test_zero_skip;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_reader.md
CALC_READER -- requirements
Module: calc_reader

Interface
REQ-001 clk  input  1  System clock; all state updates on rising edge.
REQ-002 rst  input  1  Reset, asynchronous, active-high; all registers forced to reset values while high.
REQ-003 start  input  1  Readout request, sampled on clk; honoured only in IDLE.
REQ-004 g2sum  input  14  Unsigned sum of g squared for the lane currently presented by the accumulator.
REQ-005 gsum  input  11  Unsigned sum of g for the presented lane.
REQ-006 fg  input  14  Unsigned sum of f times g for the presented lane.
REQ-007 place  input  6  Disparity position of the presented lane.
REQ-008 finalstart  output  1  One-cycle strobe selecting lane 0 in the accumulator.
REQ-009 valid  output  1  One-cycle strobe advancing the accumulator to the next lane.
REQ-010 busy  output  1  High from start acceptance until done.
REQ-011 done  output  1  One-cycle pulse when all 4 lanes have been evaluated.
REQ-012 best_place  output  6  Place of the winning lane.
REQ-013 best_score  output  16  Signed score of the winning lane.
REQ-014 best_valid  output  1  High when at least one lane was eligible in the last readout.

Function
REQ-015 FSM states: IDLE, STROBE, SETTLE, CAPTURE, FIN; 2-bit lane counter lane_idx.
REQ-016 IDLE and start=1 SHALL go to STROBE with lane_idx=0, busy=1, clearing best_valid, best_score and best_place.
REQ-017 STROBE SHALL last one cycle: finalstart=1 when lane_idx=0, otherwise valid=1; never both.
REQ-018 SETTLE SHALL last one cycle with both strobes low.
REQ-019 CAPTURE SHALL register g2sum, gsum, fg, place and compute score = zero-extended g2sum minus 2*fg, 16-bit two's complement.
REQ-020 In CAPTURE, an eligible lane SHALL replace the best when best_valid=0 or score < best_score (signed); on a tie the earlier lane is kept.
REQ-021 CAPTURE with lane_idx<3 SHALL increment lane_idx and go to STROBE; with lane_idx=3 it SHALL go to FIN.
REQ-022 FIN SHALL assert done=1 for one cycle, set busy=0, and return to IDLE.
REQ-023 Latency: start sampled at cycle 0, finalstart at cycle 1, valid at cycles 4, 7 and 10, done at cycle 13.
REQ-024 start while busy SHALL be ignored without restart or queueing.
REQ-025 best_place, best_score and best_valid SHALL hold their values from FIN until the next accepted start.
REQ-026 Score SHALL NOT saturate: the range is -32766 to 16383, which fits in 16 bits.

Reset
REQ-027 While rst=1: state=IDLE, lane_idx=0, finalstart=0, valid=0, busy=0, done=0, best_place=0, best_score=0, best_valid=0.
REQ-028 rst mid-readout SHALL abort immediately with no done pulse; the next start after release begins again at lane 0.

Configuration
REQ-029 Macro CALC_READER_ZERO_SKIP_EN defined: a lane with gsum=0 SHALL be ineligible for best selection.
REQ-030 Macro CALC_READER_ZERO_SKIP_EN undefined: all four lanes SHALL be eligible, so best_valid=1 after every completed readout.
REQ-031 With the macro defined and all four lanes having gsum=0: done SHALL still pulse, with best_valid=0 and best_place=0.

Verification
REQ-032 Lanes (g2sum, fg, place) = (100,10,0), (50,40,16), (80,20,32), (90,60,48) -> scores 80, -30, 40, -30; best_place=16, best_score=-30 (tie keeps lane 1); done at cycle 13.
REQ-033 Strobe timing after start: finalstart at cycle 1, valid at cycles 4, 7 and 10 only; busy high for cycles 1-13.
REQ-034 start pulsed again at cycle 5 -> ignored; exactly one done pulse, at cycle 13.
REQ-035 rst asserted at cycle 8, then released and start reissued -> no done pulse from the first run; second run gives the correct result.
REQ-036 ZERO_SKIP_EN defined, lanes 0-2 have gsum=0 and lane 3 has gsum=5, g2sum=16383, fg=0 -> best_place=lane 3 place, best_score=16383, best_valid=1.
REQ-037 Extreme lane with g2sum=0 and fg=16383 -> best_score=-32766, no wrap.
